// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipeline.
// Produces pipeline-register stall/flush controls, EX-stage forwarding selects,
// a data-memory wait FSM with timeout, and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [1:0]       ResultSrc_E,
    input  logic             PCSrc_E,
    input  logic [4:0]       Rd_M,
    input  logic             RegWrite_M,
    input  logic             MemWrite_M,
    input  logic [1:0]       ResultSrc_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_W,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             mem_err_nxt;

    logic lw_stall;
    logic mem_req;
    logic freeze;

    // EX-stage operand forwarding; the younger MEM result wins over WB
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (Rs1_E != 5'd0 && RegWrite_M && Rs1_E == Rd_M) begin
            ForwardAE = 2'b10;
        end else if (Rs1_E != 5'd0 && RegWrite_W && Rs1_E == Rd_W) begin
            ForwardAE = 2'b01;
        end
        if (Rs2_E != 5'd0 && RegWrite_M && Rs2_E == Rd_M) begin
            ForwardBE = 2'b10;
        end else if (Rs2_E != 5'd0 && RegWrite_W && Rs2_E == Rd_W) begin
            ForwardBE = 2'b01;
        end
    end

    // Hazard detection: load-use in decode, outstanding data-memory access
    always_comb begin
        lw_stall = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                   ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));
        mem_req  = MemWrite_M || (ResultSrc_M == 2'b01);
        freeze   = (mem_req && !dmem_ready) || (state == ERR);
    end

    // Pipeline controls; a freeze suppresses flushes so a redirect waits for it to drop
    always_comb begin
        StallF = lw_stall || freeze;
        StallD = lw_stall || freeze;
        StallE = freeze;
        StallM = freeze;
        FlushW = freeze;
        FlushD = PCSrc_E && !freeze;
        FlushE = (lw_stall || PCSrc_E) && !freeze;
    end

    // Wait FSM state, wait counter and sticky error register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    // Wait FSM next state; a dropped request without ready is treated as done
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;
        case (state)
            IDLE: begin
                if (mem_req && !dmem_ready) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = CNT_ONE;
                end
            end
            WAIT: begin
                if (dmem_ready || !mem_req) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TIMEOUT_V) begin
                    state_nxt   = ERR;
                    mem_err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_ONE;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Saturating debug counters of stall and flush cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (FlushD && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Expected outputs are queued as stimulus is applied and compared at the falling edge.
module tb_hazard_ctrl;

    localparam int unsigned TO   = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic          clk;
    logic          rst;
    logic [4:0]    Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic [1:0]    ResultSrc_E, ResultSrc_M;
    logic          PCSrc_E, RegWrite_M, MemWrite_M, RegWrite_W, dmem_ready;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic          stall_f;
        logic          stall_d;
        logic          stall_e;
        logic          stall_m;
        logic          flush_d;
        logic          flush_e;
        logic          flush_w;
        logic [1:0]    fwd_a;
        logic [1:0]    fwd_b;
        logic          err;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
    } obs_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww;
        logic [1:0] fa;
        logic [1:0] fb;
    } fwd_vec_t;

    obs_t sb_q[$];
    int   n_total;
    int   n_pass;
    int   e_stall;
    int   e_flush;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
        .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
        .Rd_W(Rd_W), .RegWrite_W(RegWrite_W), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle; advances the bench's counter model afterwards
    function automatic obs_t expect_out(logic sfd, logic frz, logic fd, logic fe,
                                        logic [1:0] fa, logic [1:0] fb, logic err);
        obs_t e;
        e.stall_f = sfd;
        e.stall_d = sfd;
        e.stall_e = frz;
        e.stall_m = frz;
        e.flush_w = frz;
        e.flush_d = fd;
        e.flush_e = fe;
        e.fwd_a   = fa;
        e.fwd_b   = fb;
        e.err     = err;
        e.scnt    = CW'(e_stall);
        e.fcnt    = CW'(e_flush);
        if (sfd && e_stall < CMAX) e_stall++;
        if (fd && e_flush < CMAX) e_flush++;
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.stall_f = StallF;
        o.stall_d = StallD;
        o.stall_e = StallE;
        o.stall_m = StallM;
        o.flush_d = FlushD;
        o.flush_e = FlushE;
        o.flush_w = FlushW;
        o.fwd_a   = ForwardAE;
        o.fwd_b   = ForwardBE;
        o.err     = mem_err;
        o.scnt    = stall_cnt;
        o.fcnt    = flush_cnt;
        return o;
    endfunction

    task automatic clear_inputs();
        Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; Rd_E = '0;
        ResultSrc_E = '0; PCSrc_E = 1'b0; Rd_M = '0; RegWrite_M = 1'b0;
        MemWrite_M = 1'b0; ResultSrc_M = '0; Rd_W = '0; RegWrite_W = 1'b0;
        dmem_ready = 1'b0;
    endtask

    // Entered and left one time unit after a rising edge
    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        e_stall = 0;
        e_flush = 0;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(expect_out(0, 0, 0, 0, 2'b00, 2'b00, 0));
            @(negedge clk);
            got = observe(); want = sb_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL reset[%0d]: got %h want %h", i, got, want);
            else n_pass++;
            @(posedge clk); #1;
            rst = 1'b1;
        end
    endtask

    task automatic test_forwarding();
        obs_t got, want;
        fwd_vec_t tbl [7];
        tbl[0] = '{5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b10, 2'b00};
        tbl[1] = '{5'd5, 5'd0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b01, 2'b00};
        tbl[2] = '{5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 2'b10, 2'b10};
        tbl[3] = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00};
        tbl[4] = '{5'd3, 5'd9, 5'd5, 1'b1, 5'd9, 1'b1, 2'b00, 2'b01};
        tbl[5] = '{5'd9, 5'd3, 5'd3, 1'b1, 5'd9, 1'b0, 2'b00, 2'b10};
        tbl[6] = '{5'd4, 5'd4, 5'd4, 1'b0, 5'd4, 1'b0, 2'b00, 2'b00};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            Rs1_E = tbl[i].rs1; Rs2_E = tbl[i].rs2;
            Rd_M = tbl[i].rdm; RegWrite_M = tbl[i].rwm;
            Rd_W = tbl[i].rdw; RegWrite_W = tbl[i].rww;
            sb_q.push_back(expect_out(0, 0, 0, 0, tbl[i].fa, tbl[i].fb, 0));
            @(negedge clk);
            got = observe(); want = sb_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL forwarding[%0d]: got %h want %h", i, got, want);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        obs_t got, want;
        logic [1:0] rse [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
        logic [4:0] rde [5] = '{5'd7, 5'd7, 5'd0, 5'd7, 5'd0};
        logic [4:0] r1d [5] = '{5'd0, 5'd7, 5'd0, 5'd7, 5'd0};
        logic [4:0] r2d [5] = '{5'd7, 5'd0, 5'd0, 5'd7, 5'd0};
        logic       stl [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ResultSrc_E = rse[i]; Rd_E = rde[i]; Rs1_D = r1d[i]; Rs2_D = r2d[i];
            sb_q.push_back(expect_out(stl[i], 0, 0, stl[i], 2'b00, 2'b00, 0));
            @(negedge clk);
            got = observe(); want = sb_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL load_use[%0d]: got %h want %h", i, got, want);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    PCSrc_E = 1'b1;
                    sb_q.push_back(expect_out(0, 0, 1, 1, 2'b00, 2'b00, 0));
                end
                2: begin
                    PCSrc_E = 1'b1; ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs2_D = 5'd7;
                    sb_q.push_back(expect_out(1, 0, 1, 1, 2'b00, 2'b00, 0));
                end
                default: sb_q.push_back(expect_out(0, 0, 0, 0, 2'b00, 2'b00, 0));
            endcase
            @(negedge clk);
            got = observe(); want = sb_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL branch[%0d]: got %h want %h", i, got, want);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            clear_inputs();
            case (i)
                0, 1, 2: begin
                    ResultSrc_M = 2'b01;
                    sb_q.push_back(expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0));
                end
                3: begin
                    ResultSrc_M = 2'b01; dmem_ready = 1'b1;
                    sb_q.push_back(expect_out(0, 0, 0, 0, 2'b00, 2'b00, 0));
                end
                5, 6: begin
                    MemWrite_M = 1'b1; PCSrc_E = 1'b1;
                    sb_q.push_back(expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0));
                end
                7: begin
                    MemWrite_M = 1'b1; PCSrc_E = 1'b1; dmem_ready = 1'b1;
                    sb_q.push_back(expect_out(0, 0, 1, 1, 2'b00, 2'b00, 0));
                end
                9: begin
                    ResultSrc_M = 2'b01; dmem_ready = 1'b1;
                    sb_q.push_back(expect_out(0, 0, 0, 0, 2'b00, 2'b00, 0));
                end
                11: begin
                    ResultSrc_M = 2'b01; ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs1_D = 5'd7;
                    sb_q.push_back(expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0));
                end
                12: begin
                    ResultSrc_M = 2'b01; dmem_ready = 1'b1;
                    ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs1_D = 5'd7;
                    sb_q.push_back(expect_out(1, 0, 0, 1, 2'b00, 2'b00, 0));
                end
                default: sb_q.push_back(expect_out(0, 0, 0, 0, 2'b00, 2'b00, 0));
            endcase
            @(negedge clk);
            got = observe(); want = sb_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL mem_wait[%0d]: got %h want %h", i, got, want);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_drop();
        obs_t got, want;
        logic req [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic rdy [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            ResultSrc_M = req[i] ? 2'b01 : 2'b00;
            dmem_ready  = rdy[i];
            sb_q.push_back(expect_out(req[i] && !rdy[i], req[i] && !rdy[i], 0, 0,
                                      2'b00, 2'b00, 0));
            @(negedge clk);
            got = observe(); want = sb_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL wait_drop[%0d]: got %h want %h", i, got, want);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            if (i < 8) begin
                ResultSrc_M = 2'b01;
            end else begin
                dmem_ready = 1'b1; PCSrc_E = 1'b1;
            end
            sb_q.push_back(expect_out(1, 1, 0, 0, 2'b00, 2'b00, i >= 5));
            @(negedge clk);
            got = observe(); want = sb_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL timeout[%0d]: got %h want %h", i, got, want);
            else n_pass++;
            @(posedge clk); #1;
        end
        // Asynchronous reset in ERR while a request is still pending
        clear_inputs();
        ResultSrc_M = 2'b01;
        rst = 1'b0;
        e_stall = 0;
        e_flush = 0;
        sb_q.push_back(expect_out(1, 1, 0, 0, 2'b00, 2'b00, 0));
        e_stall = 0;
        #1;
        got = observe(); want = sb_q.pop_front(); n_total++;
        if (got !== want) $display("FAIL async_reset_req: got %h want %h", got, want);
        else n_pass++;
        ResultSrc_M = 2'b00;
        sb_q.push_back(expect_out(0, 0, 0, 0, 2'b00, 2'b00, 0));
        #1;
        got = observe(); want = sb_q.pop_front(); n_total++;
        if (got !== want) $display("FAIL async_reset_idle: got %h want %h", got, want);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.push_back(expect_out(0, 0, 0, 0, 2'b00, 2'b00, 0));
        @(negedge clk);
        got = observe(); want = sb_q.pop_front(); n_total++;
        if (got !== want) $display("FAIL after_reset: got %h want %h", got, want);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 41; i++) begin
            clear_inputs();
            if (i < 20) begin
                ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs1_D = 5'd7;
                sb_q.push_back(expect_out(1, 0, 0, 1, 2'b00, 2'b00, 0));
            end else if (i < 40) begin
                PCSrc_E = 1'b1;
                sb_q.push_back(expect_out(0, 0, 1, 1, 2'b00, 2'b00, 0));
            end else begin
                sb_q.push_back(expect_out(0, 0, 0, 0, 2'b00, 2'b00, 0));
            end
            @(negedge clk);
            got = observe(); want = sb_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL saturation[%0d]: got %h want %h", i, got, want);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        e_stall = 0;
        e_flush = 0;
        rst     = 1'b0;
        clear_inputs();
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_wait_drop();
        test_timeout();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
